// File: rtl/bypass_producer_pkg.sv
// ----------------------------------------------------------------------------
// bypass_producer_pkg
// Shared definitions for the execute-stage bypass network. The producer
// (bypass_producer) and the operand forward-check consumers both import
// this package so they agree on the lane count, tag width and data width.
//
// Contents:
//   BP_NUM_LANES          default number of result lanes / bypass buses
//   BP_SIZE_PHYSICAL_LOG  default physical register tag width
//   BP_SIZE_DATA          default result data width
//   BP_CNT_W              default width of the valid-lane count
//   bp_result_t           one lane's result (valid, tag, data)
//   BP_LANE_FIELD         macro selecting lane i of a flat packed bus
// ----------------------------------------------------------------------------
`ifndef BYPASS_PRODUCER_PKG_SV
`define BYPASS_PRODUCER_PKG_SV

// Lane i of a flat bus whose lanes are w bits wide, lane 0 in the LSBs.
`define BP_LANE_FIELD(vec, i, w) vec[(i)*(w) +: (w)]

package bypass_producer_pkg;

    localparam int BP_NUM_LANES         = 6;
    localparam int BP_SIZE_PHYSICAL_LOG = 7;
    localparam int BP_SIZE_DATA         = 32;
    localparam int BP_CNT_W             = 3;

    typedef struct packed {
        logic                            valid;
        logic [BP_SIZE_PHYSICAL_LOG-1:0] tag;
        logic [BP_SIZE_DATA-1:0]         data;
    } bp_result_t;

endpackage

`endif

// File: rtl/bypass_lane_stage.sv
// ----------------------------------------------------------------------------
// bypass_lane_stage
// One result lane of the bypass producer: an S1 register that drives the
// bypass bus, followed by an S2 register that drives one register file
// write port.
//
// Ports:
//   clk, reset         clock (rising edge), synchronous active-low reset
//   stall_i            hold S1 and S2, suppress the write enable
//   flush_i            clear the S1 valid bit on this edge
//   in_valid_i/tag/data  functional-unit result entering S1
//   s1_valid_o/tag/data  S1 contents (bypass bus)
//   wr_en_o/addr/data    S2 contents (register file write port)
// ----------------------------------------------------------------------------
module bypass_lane_stage
    import bypass_producer_pkg::*;
#(
    parameter int TAG_W  = BP_SIZE_PHYSICAL_LOG,
    parameter int DATA_W = BP_SIZE_DATA
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              s1_valid_o,
    output logic [TAG_W-1:0]  s1_tag_o,
    output logic [DATA_W-1:0] s1_data_o,
    output logic              wr_en_o,
    output logic [TAG_W-1:0]  wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o
);

    logic              s1_valid_q, s1_valid_d;
    logic [TAG_W-1:0]  s1_tag_q,   s1_tag_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic              s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0]  s2_tag_q,   s2_tag_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;

    // Tag and data load without regard to valid; only the valid bits
    // carry meaning for consumers. A flush overrides the stall hold on the
    // S1 valid so squashed results never linger on the bypass.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_tag_d   = s1_tag_q;
        s1_data_d  = s1_data_q;
        s2_valid_d = s2_valid_q;
        s2_tag_d   = s2_tag_q;
        s2_data_d  = s2_data_q;
        if (!stall_i) begin
            s1_valid_d = in_valid_i;
            s1_tag_d   = in_tag_i;
            s1_data_d  = in_data_i;
            s2_valid_d = s1_valid_q;
            s2_tag_d   = s1_tag_q;
            s2_data_d  = s1_data_q;
        end
        if (flush_i) begin
            s1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_tag_q   <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_tag_q   <= s1_tag_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_tag_q   <= s2_tag_d;
            s2_data_q  <= s2_data_d;
        end
    end

    // A held S2 entry must write exactly once, in its first unstalled
    // cycle, and nothing may write while reset is discarding the pipeline.
    assign wr_en_o    = s2_valid_q & ~stall_i & reset;
    assign wr_addr_o  = s2_tag_q;
    assign wr_data_o  = s2_data_q;
    assign s1_valid_o = s1_valid_q;
    assign s1_tag_o   = s1_tag_q;
    assign s1_data_o  = s1_data_q;

endmodule

// File: rtl/bypass_producer.sv
// ----------------------------------------------------------------------------
// bypass_producer
// Source side of the execute-stage bypass network. Functional-unit results
// are registered into S1 (bypass buses, visible one cycle after the result)
// and then S2 (register file write ports, two cycles after the result), so
// the bypass covers the gap before the register file is written.
//
// Ports:
//   clk, reset        clock (rising edge), synchronous active-low reset
//   stall_i           freeze S1/S2, write enables forced low
//   flush_i           squash S1 valids; S2 still completes its write
//   resultValid_i/Tag_i/Data_i   per-lane inputs, lane i at [i*W +: W]
//   bypassValid_o/Tag_o/Data_o   S1 contents per lane
//   bypassCount_o     number of valid S1 lanes
//   rfWrEn_o/rfWrAddr_o/rfWrData_o  S2 register file write ports
//   dupErr_o          sticky duplicate-tag error
//
// Build option: define BYPASS_DUP_TAG_CHECK_EN to compare all valid input
// lane tags each unstalled cycle and latch dupErr_o on any match. Without
// it no comparators are built and dupErr_o is tied low.
// ----------------------------------------------------------------------------
module bypass_producer
    import bypass_producer_pkg::*;
#(
    parameter int NUM_LANES         = BP_NUM_LANES,
    parameter int SIZE_PHYSICAL_LOG = BP_SIZE_PHYSICAL_LOG,
    parameter int SIZE_DATA         = BP_SIZE_DATA,
    parameter int CNT_W             = BP_CNT_W
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   stall_i,
    input  logic                                   flush_i,
    input  logic [NUM_LANES-1:0]                   resultValid_i,
    input  logic [NUM_LANES*SIZE_PHYSICAL_LOG-1:0] resultTag_i,
    input  logic [NUM_LANES*SIZE_DATA-1:0]         resultData_i,
    output logic [NUM_LANES-1:0]                   bypassValid_o,
    output logic [NUM_LANES*SIZE_PHYSICAL_LOG-1:0] bypassTag_o,
    output logic [NUM_LANES*SIZE_DATA-1:0]         bypassData_o,
    output logic [CNT_W-1:0]                       bypassCount_o,
    output logic [NUM_LANES-1:0]                   rfWrEn_o,
    output logic [NUM_LANES*SIZE_PHYSICAL_LOG-1:0] rfWrAddr_o,
    output logic [NUM_LANES*SIZE_DATA-1:0]         rfWrData_o,
    output logic                                   dupErr_o
);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        bypass_lane_stage #(
            .TAG_W  (SIZE_PHYSICAL_LOG),
            .DATA_W (SIZE_DATA)
        ) u_lane (
            .clk        (clk),
            .reset      (reset),
            .stall_i    (stall_i),
            .flush_i    (flush_i),
            .in_valid_i (resultValid_i[i]),
            .in_tag_i   (`BP_LANE_FIELD(resultTag_i, i, SIZE_PHYSICAL_LOG)),
            .in_data_i  (`BP_LANE_FIELD(resultData_i, i, SIZE_DATA)),
            .s1_valid_o (bypassValid_o[i]),
            .s1_tag_o   (`BP_LANE_FIELD(bypassTag_o, i, SIZE_PHYSICAL_LOG)),
            .s1_data_o  (`BP_LANE_FIELD(bypassData_o, i, SIZE_DATA)),
            .wr_en_o    (rfWrEn_o[i]),
            .wr_addr_o  (`BP_LANE_FIELD(rfWrAddr_o, i, SIZE_PHYSICAL_LOG)),
            .wr_data_o  (`BP_LANE_FIELD(rfWrData_o, i, SIZE_DATA))
        );
    end

    logic [CNT_W-1:0] valid_count;

    // Popcount of the S1 valid bits; CNT_W is wide enough for NUM_LANES.
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            valid_count = valid_count + CNT_W'(bypassValid_o[i]);
        end
    end

    assign bypassCount_o = valid_count;

`ifdef BYPASS_DUP_TAG_CHECK_EN
    logic dup_hit;
    logic dup_err_q, dup_err_d;

    // Upstream must never send two valid lanes with the same tag; any such
    // pair in an accepted (unstalled) cycle latches a sticky error.
    always_comb begin
        dup_hit = 1'b0;
        if (!stall_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int j = i + 1; j < NUM_LANES; j++) begin
                    if (resultValid_i[i] && resultValid_i[j] &&
                        (`BP_LANE_FIELD(resultTag_i, i, SIZE_PHYSICAL_LOG) ==
                         `BP_LANE_FIELD(resultTag_i, j, SIZE_PHYSICAL_LOG))) begin
                        dup_hit = 1'b1;
                    end
                end
            end
        end
        dup_err_d = dup_err_q | dup_hit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            dup_err_q <= 1'b0;
        end else begin
            dup_err_q <= dup_err_d;
        end
    end

    assign dupErr_o = dup_err_q;

`ifndef SYNTHESIS
    // Simulation-only report naming the offending lanes and tag.
    always_ff @(posedge clk) begin
        if (reset && !stall_i) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                for (int j = i + 1; j < NUM_LANES; j++) begin
                    if (resultValid_i[i] && resultValid_i[j] &&
                        (`BP_LANE_FIELD(resultTag_i, i, SIZE_PHYSICAL_LOG) ==
                         `BP_LANE_FIELD(resultTag_i, j, SIZE_PHYSICAL_LOG))) begin
                        $display("bypass_producer: duplicate tag %0d on lanes %0d and %0d",
                                 `BP_LANE_FIELD(resultTag_i, i, SIZE_PHYSICAL_LOG), i, j);
                    end
                end
            end
        end
    end
`endif
`else
    assign dupErr_o = 1'b0;
`endif

endmodule
